// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt entry sequencer.
// Contents: FSM state encoding, interrupt-controller io register
// addresses, source indices and source count.
package intr_pkg;

    localparam int unsigned NSRC = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDPEND,
        S_CLEAR,
        S_TRAP,
        S_HANDLER
    } state_e;

    // Interrupt controller io register map
    localparam logic [3:0] INTR_PEND = 4'd0;
    localparam logic [3:0] INTR_STAT = 4'd1;
    localparam logic [3:0] INTR_EN   = 4'd2;
    localparam logic [3:0] INTR_SET  = 4'd4;
    localparam logic [3:0] INTR_CLR  = 4'd5;

    // Source indices; a lower index means a higher priority
    localparam logic [2:0] SRC_UART  = 3'd0;
    localparam logic [2:0] SRC_CLOCK = 3'd1;
    localparam logic [2:0] SRC_TIMER = 3'd2;
    localparam logic [2:0] SRC_SWI   = 3'd3;
    localparam logic [2:0] SRC_SD    = 3'd4;

endpackage

// File: rtl/intr_seq_prio_enc5.sv
// prio_enc5: lowest-set-bit encoder over the interrupt sources.
// Ports:
//   req_i   - pending source bits
//   idx_o   - index of the lowest set bit (0 when none set)
//   valid_o - at least one bit set
module prio_enc5
    import intr_pkg::*;
(
    input  logic [NSRC-1:0] req_i,
    output logic [2:0]      idx_o,
    output logic            valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Scan from the top down so the lowest set bit is written last.
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (req_i[NSRC-1-i]) begin
                idx_o = 3'(NSRC - 1 - i);
            end
        end
    end

endmodule

// File: rtl/intr_seq.sv
// intr_seq: CPU-side interrupt entry sequencer.
// Samples the controller's interrupt line at instruction boundaries, reads
// the pending register over the io bus, optionally clears the selected
// source, then raises a vectored trap request and masks further entry until
// the handler returns.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   interrupt                         - OR of enabled pending sources
//   cpu_boundary                      - core may take a trap this cycle
//   cpu_ei / cpu_di / cpu_rti         - IE set / IE clear / handler return
//   trap_req, trap_vector, trap_ack   - trap handshake with the core
//   io_req, io_write, io_addr,
//   io_wdata, io_rdata, io_gnt        - io-bus initiator
//   ie, in_handler, cause             - status
module intr_seq
    import intr_pkg::*;
#(
    parameter logic [15:0] VEC_BASE  = 16'h0010,
    parameter int unsigned VEC_SHIFT = 2,
    parameter logic [4:0]  AUTO_CLR  = 5'b01110
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        interrupt,
    input  logic        cpu_boundary,
    input  logic        cpu_ei,
    input  logic        cpu_di,
    input  logic        cpu_rti,
    output logic        trap_req,
    output logic [15:0] trap_vector,
    input  logic        trap_ack,
    output logic        io_req,
    output logic        io_write,
    output logic [3:0]  io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_gnt,
    output logic        ie,
    output logic        in_handler,
    output logic [2:0]  cause
);

    state_e      state_q, state_d;
    logic        ie_q, ie_d;
    logic        sie_q, sie_d;
    logic        inh_q, inh_d;
    logic        treq_q, treq_d;
    logic [15:0] tvec_q, tvec_d;
    logic        ioreq_q, ioreq_d;
    logic        iowr_q, iowr_d;
    logic [3:0]  ioaddr_q, ioaddr_d;
    logic [15:0] iowd_q, iowd_d;
    logic [2:0]  cause_q, cause_d;

    logic [2:0]  enc_idx;
    logic        enc_vld;
    logic [15:0] vec_calc;
    logic [15:0] clr_mask;
    logic        entry;
    logic        ret;
    logic        unused_rdata;

    // Only the low source bits of the pending register are meaningful.
    assign unused_rdata = ^io_rdata[15:NSRC];

    prio_enc5 u_enc (
        .req_i   (io_rdata[NSRC-1:0]),
        .idx_o   (enc_idx),
        .valid_o (enc_vld)
    );

    // 16-bit add wraps on overflow by construction.
    assign vec_calc = VEC_BASE + ({13'd0, enc_idx} << VEC_SHIFT);
    assign clr_mask = 16'h0001 << enc_idx;

    always_comb begin
        state_d  = state_q;
        sie_d    = sie_q;
        inh_d    = inh_q;
        treq_d   = treq_q;
        tvec_d   = tvec_q;
        ioreq_d  = ioreq_q;
        iowr_d   = iowr_q;
        ioaddr_d = ioaddr_q;
        iowd_d   = iowd_q;
        cause_d  = cause_q;
        entry    = 1'b0;
        ret      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (interrupt && ie_q && cpu_boundary && !cpu_di) begin
                    state_d  = S_RDPEND;
                    ioreq_d  = 1'b1;
                    iowr_d   = 1'b0;
                    ioaddr_d = INTR_PEND;
                end
            end
            S_RDPEND: begin
                if (io_gnt) begin
                    ioreq_d = 1'b0;
                    if (!enc_vld) begin
                        // Source vanished between sampling and the read.
                        state_d = S_IDLE;
                    end else begin
                        cause_d = enc_idx;
                        tvec_d  = vec_calc;
                        if (AUTO_CLR[enc_idx]) begin
                            state_d  = S_CLEAR;
                            ioreq_d  = 1'b1;
                            iowr_d   = 1'b1;
                            ioaddr_d = INTR_CLR;
                            iowd_d   = clr_mask;
                        end else begin
                            state_d = S_TRAP;
                            treq_d  = 1'b1;
                        end
                    end
                end
            end
            S_CLEAR: begin
                if (io_gnt) begin
                    ioreq_d = 1'b0;
                    iowr_d  = 1'b0;
                    state_d = S_TRAP;
                    treq_d  = 1'b1;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    treq_d  = 1'b0;
                    sie_d   = ie_q;
                    inh_d   = 1'b1;
                    state_d = S_HANDLER;
                    entry   = 1'b1;
                end
            end
            S_HANDLER: begin
                if (cpu_rti) begin
                    inh_d   = 1'b0;
                    state_d = S_IDLE;
                    ret     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Priority: disable > trap entry > handler return > enable.
        if (cpu_di) begin
            ie_d = 1'b0;
        end else if (entry) begin
            ie_d = 1'b0;
        end else if (ret) begin
            ie_d = sie_q;
        end else if (cpu_ei) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ie_q     <= 1'b0;
            sie_q    <= 1'b0;
            inh_q    <= 1'b0;
            treq_q   <= 1'b0;
            tvec_q   <= '0;
            ioreq_q  <= 1'b0;
            iowr_q   <= 1'b0;
            ioaddr_q <= '0;
            iowd_q   <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            ie_q     <= ie_d;
            sie_q    <= sie_d;
            inh_q    <= inh_d;
            treq_q   <= treq_d;
            tvec_q   <= tvec_d;
            ioreq_q  <= ioreq_d;
            iowr_q   <= iowr_d;
            ioaddr_q <= ioaddr_d;
            iowd_q   <= iowd_d;
            cause_q  <= cause_d;
        end
    end

    assign trap_req    = treq_q;
    assign trap_vector = tvec_q;
    assign io_req      = ioreq_q;
    assign io_write    = iowr_q;
    assign io_addr     = ioaddr_q;
    assign io_wdata    = iowd_q;
    assign ie          = ie_q;
    assign in_handler  = inh_q;
    assign cause       = cause_q;

endmodule

// File: tb/tb_intr_seq.sv
// Self-checking bench for intr_seq: directed scenarios followed by random
// interrupt services, checked against a transaction-level model of the
// entry sequence (lowest pending bit wins, auto-clear mask, vector table,
// IE save/restore).
module tb_intr_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        interrupt, cpu_boundary, cpu_ei, cpu_di, cpu_rti;
    logic        trap_req, trap_ack;
    logic [15:0] trap_vector;
    logic        io_req, io_write, io_gnt;
    logic [3:0]  io_addr;
    logic [15:0] io_wdata, io_rdata;
    logic        ie, in_handler;
    logic [2:0]  cause;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_ie    = 1'b0;

    localparam logic [15:0] M_BASE = 16'h0010;
    localparam logic [4:0]  M_AUTO = 5'b01110;

    intr_seq #(.VEC_BASE(16'h0010), .VEC_SHIFT(2), .AUTO_CLR(5'b01110)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .interrupt    (interrupt),
        .cpu_boundary (cpu_boundary),
        .cpu_ei       (cpu_ei),
        .cpu_di       (cpu_di),
        .cpu_rti      (cpu_rti),
        .trap_req     (trap_req),
        .trap_vector  (trap_vector),
        .trap_ack     (trap_ack),
        .io_req       (io_req),
        .io_write     (io_write),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_rdata     (io_rdata),
        .io_gnt       (io_gnt),
        .ie           (ie),
        .in_handler   (in_handler),
        .cause        (cause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest_src(input logic [4:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    // One complete service attempt, starting in IDLE with ie=1.
    task automatic take_irq(input logic [4:0] p, input int rd_wait, input int wr_wait,
                            input bit di_mid, input bit stray_mid, input bit ei_in_h);
        int          c;
        bit          saved;
        logic [4:0]  am;
        logic [15:0] r;
        am = M_AUTO;
        c  = lowest_src(p);

        interrupt = 1'b1; cpu_boundary = 1'b1;
        tick();
        interrupt = 1'b0; cpu_boundary = 1'b0;
        chk("rd_req",   io_req,   1);
        chk("rd_write", io_write, 0);
        chk("rd_addr",  io_addr,  0);
        chk("rd_treq",  trap_req, 0);

        // Late disable is committed-through; rti/ack here must be ignored.
        if (stray_mid) begin cpu_rti = 1'b1; trap_ack = 1'b1; end
        if (di_mid) begin cpu_di = 1'b1; m_ie = 1'b0; end
        for (int i = 0; i < rd_wait; i++) begin
            tick();
            cpu_rti = 1'b0; trap_ack = 1'b0; cpu_di = 1'b0;
            chk("rd_hold_req",  io_req,  1);
            chk("rd_hold_addr", io_addr, 0);
            chk("rd_hold_wr",   io_write, 0);
        end
        r = 16'($urandom);
        io_gnt = 1'b1; io_rdata = {r[15:5], p};
        tick();
        io_gnt = 1'b0; io_rdata = 16'($urandom);
        cpu_rti = 1'b0; trap_ack = 1'b0; cpu_di = 1'b0;

        if (c < 0) begin
            chk("spur_ioreq", io_req, 0);
            for (int i = 0; i < 3; i++) begin
                chk("spur_treq", trap_req, 0);
                tick();
            end
            chk("spur_ie", ie, m_ie);
            chk("spur_inh", in_handler, 0);
        end else begin
            if (am[c]) begin
                chk("clr_req",   io_req,   1);
                chk("clr_write", io_write, 1);
                chk("clr_addr",  io_addr,  5);
                chk("clr_wdata", io_wdata, 16'h0001 << c);
                chk("clr_treq",  trap_req, 0);
                for (int i = 0; i < wr_wait; i++) begin
                    tick();
                    chk("clr_hold_req",  io_req,  1);
                    chk("clr_hold_addr", io_addr, 5);
                end
                io_gnt = 1'b1;
                tick();
                io_gnt = 1'b0;
            end
            chk("trap_ioreq", io_req, 0);
            chk("trap_req",   trap_req, 1);
            chk("trap_vec",   trap_vector, 16'(M_BASE + 16'(c * 4)));
            chk("trap_cause", cause, c);
            chk("trap_ie",    ie, m_ie);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                tick();
                chk("trap_hold", trap_req, 1);
            end
            saved = m_ie;
            trap_ack = 1'b1;
            tick();
            trap_ack = 1'b0;
            m_ie = 1'b0;
            chk("ack_treq", trap_req, 0);
            chk("ack_ie",   ie, 0);
            chk("ack_inh",  in_handler, 1);
            if (ei_in_h) begin
                cpu_ei = 1'b1;
                tick();
                cpu_ei = 1'b0;
                m_ie = 1'b1;
                chk("h_ei_ie",  ie, 1);
                chk("h_ei_inh", in_handler, 1);
            end
            // No nested entry while in the handler.
            interrupt = 1'b1; cpu_boundary = 1'b1;
            tick();
            interrupt = 1'b0; cpu_boundary = 1'b0;
            chk("h_no_nest", io_req, 0);
            cpu_rti = 1'b1;
            tick();
            cpu_rti = 1'b0;
            m_ie = saved;
            chk("rti_ie",  ie, m_ie);
            chk("rti_inh", in_handler, 0);
        end
        if (!m_ie) begin
            cpu_ei = 1'b1;
            tick();
            cpu_ei = 1'b0;
            m_ie = 1'b1;
            chk("reen_ie", ie, 1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        interrupt = 1'b0; cpu_boundary = 1'b0; cpu_ei = 1'b0; cpu_di = 1'b0;
        cpu_rti = 1'b0; trap_ack = 1'b0; io_gnt = 1'b0; io_rdata = '0;
        #2;
        chk("rst_ie",    ie, 0);
        chk("rst_inh",   in_handler, 0);
        chk("rst_treq",  trap_req, 0);
        chk("rst_ioreq", io_req, 0);
        chk("rst_iowr",  io_write, 0);
        chk("rst_cause", cause, 0);
        chk("rst_addr",  io_addr, 0);
        chk("rst_wdata", io_wdata, 0);
        chk("rst_vec",   trap_vector, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ie=0: interrupt at a boundary must not start an access.
        interrupt = 1'b1; cpu_boundary = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ie0_noreq", io_req, 0);
        end
        cpu_boundary = 1'b0;
        cpu_ei = 1'b1;
        tick();
        cpu_ei = 1'b0;
        m_ie = 1'b1;
        chk("ei_ie", ie, 1);
        // No boundary: still no access.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nobnd_noreq", io_req, 0);
        end
        interrupt = 1'b0;

        // Simultaneous enable and disable: disable wins.
        cpu_ei = 1'b1; cpu_di = 1'b1;
        tick();
        cpu_ei = 1'b0; cpu_di = 1'b0;
        m_ie = 1'b0;
        chk("eidi_ie", ie, 0);
        cpu_ei = 1'b1;
        tick();
        cpu_ei = 1'b0;
        m_ie = 1'b1;

        take_irq(5'b00001, 0, 0, 1'b0, 1'b0, 1'b0);
        take_irq(5'b00100, 0, 0, 1'b0, 1'b0, 1'b0);
        take_irq(5'b11010, 0, 0, 1'b0, 1'b0, 1'b0);
        take_irq(5'b00000, 0, 0, 1'b0, 1'b0, 1'b0);
        take_irq(5'b10000, 4, 0, 1'b0, 1'b1, 1'b1);
        take_irq(5'b01000, 1, 3, 1'b1, 1'b1, 1'b0);

        // Reset asserted mid-read between clock edges.
        interrupt = 1'b1; cpu_boundary = 1'b1;
        tick();
        interrupt = 1'b0; cpu_boundary = 1'b0;
        chk("mid_req", io_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ioreq", io_req, 0);
        chk("arst_ie",    ie, 0);
        chk("arst_addr",  io_addr, 0);
        chk("arst_treq",  trap_req, 0);
        m_ie = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ioreq", io_req, 0);
        cpu_ei = 1'b1;
        tick();
        cpu_ei = 1'b0;
        m_ie = 1'b1;
        take_irq(5'b00010, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            take_irq(5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
